// File: rtl/useq_next_addr.sv
// Sol-1 microcode sequencer: owns the micro-program counter and picks the next ROM address each clock.
// Optional micro-breakpoint support is compiled in with `define USEQ_UBREAK_EN.
module useq_next_addr #(
  parameter int          CYCLE_W    = 6,
  parameter logic [7:0]  INT_OPCODE = 8'hFF,
  localparam int         UADDR_W    = 1 + 8 + CYCLE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         typ,
  input  logic [6:0]         offset,
  input  logic               cond_invert,
  input  logic               cond_flag_src,
  input  logic [3:0]         cond_sel,
  input  logic               escape,
  input  logic [7:0]         ir,
  input  logic [15:0]        u_cond,
  input  logic [15:0]        cpu_cond,
  input  logic               int_req,
  input  logic               irq_en,
  input  logic               stall,
  output logic [UADDR_W-1:0] uaddr,
  output logic               cond_true,
  output logic               fetch_start,
  output logic               int_taken,
  output logic               seq_fault
`ifdef USEQ_UBREAK_EN
  ,
  input  logic [UADDR_W-1:0] ubrk_addr,
  input  logic               ubrk_arm,
  output logic               ubrk_hit
`endif
);

  localparam int SW = CYCLE_W + 1;
  typedef logic signed [SW-1:0] sum_t;

  logic [CYCLE_W-1:0] cyc;
  logic [15:0]        vec;
  sum_t               rel_sum;
  sum_t               inc_sum;
  sum_t               cyc_res;
  logic [UADDR_W-1:0] next_addr;
  logic               next_fault;
  logic               next_int;
  logic               next_fetch;
  logic               hold;

  assign cyc = uaddr[CYCLE_W-1:0];

  always_comb begin
    vec     = cond_flag_src ? cpu_cond : u_cond;
    vec[15] = 1'b1;
  end

  assign cond_true = vec[cond_sel] ^ cond_invert;

  // Both sums carry one extra bit: a set top bit means the cycle left 0..2^CYCLE_W-1.
  assign rel_sum = sum_t'($signed({1'b0, cyc})) + sum_t'($signed(offset));
  assign inc_sum = sum_t'($signed({1'b0, cyc})) + sum_t'(1);

  always_comb begin
    cyc_res    = inc_sum;
    next_addr  = uaddr;
    next_fault = 1'b0;
    next_int   = 1'b0;
    case (typ)
      2'd0: begin
        if (cond_true) cyc_res = rel_sum;
        next_fault = cyc_res[CYCLE_W];
        next_addr  = {uaddr[UADDR_W-1:CYCLE_W], cyc_res[CYCLE_W-1:0]};
      end
      2'd1: begin
        if (cond_true) cyc_res = {1'b0, CYCLE_W'(offset[5:0])};
        next_fault = cyc_res[CYCLE_W];
        next_addr  = {uaddr[UADDR_W-1:CYCLE_W], cyc_res[CYCLE_W-1:0]};
      end
      2'd2: begin
        if (int_req && irq_en) begin
          next_addr = {1'b0, INT_OPCODE, {CYCLE_W{1'b0}}};
          next_int  = 1'b1;
        end else begin
          next_addr = '0;
        end
      end
      default: next_addr = {escape, ir, {CYCLE_W{1'b0}}};
    endcase
    if (next_fault) next_addr = '0;
  end

  assign next_fetch = (next_addr == '0);

`ifdef USEQ_UBREAK_EN
  assign hold = stall | ubrk_hit;
`else
  assign hold = stall;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uaddr       <= '0;
      fetch_start <= 1'b1;
      int_taken   <= 1'b0;
      seq_fault   <= 1'b0;
    end else if (hold) begin
      fetch_start <= 1'b0;
      int_taken   <= 1'b0;
    end else begin
      uaddr       <= next_addr;
      fetch_start <= next_fetch;
      int_taken   <= next_int;
      if (next_fault) seq_fault <= 1'b1;
    end
  end

`ifdef USEQ_UBREAK_EN
  // The matching address is still loaded; the hit then freezes the sequencer on it.
  always_ff @(posedge clk) begin
    if (!rst_n || !ubrk_arm) ubrk_hit <= 1'b0;
    else if (!hold && next_addr == ubrk_addr) ubrk_hit <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_useq_next_addr.sv
// Bench for useq_next_addr: directed sequence with literal expectations, then random
// stimulus checked every cycle against an integer-level model of the sequencer rules.
module tb_useq_next_addr;

  localparam int CYCLE_W = 6;
  localparam int UADDR_W = 1 + 8 + CYCLE_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         typ;
  logic [6:0]         offset;
  logic               cond_invert;
  logic               cond_flag_src;
  logic [3:0]         cond_sel;
  logic               escape;
  logic [7:0]         ir;
  logic [15:0]        u_cond;
  logic [15:0]        cpu_cond;
  logic               int_req;
  logic               irq_en;
  logic               stall;
  logic [UADDR_W-1:0] uaddr;
  logic               cond_true;
  logic               fetch_start;
  logic               int_taken;
  logic               seq_fault;
`ifdef USEQ_UBREAK_EN
  logic [UADDR_W-1:0] ubrk_addr = '0;
  logic               ubrk_arm = 1'b0;
  logic               ubrk_hit;
`endif

  int n_cmp = 0;
  int n_err = 0;

  useq_next_addr dut (
    .clk(clk), .rst_n(rst_n), .typ(typ), .offset(offset),
    .cond_invert(cond_invert), .cond_flag_src(cond_flag_src), .cond_sel(cond_sel),
    .escape(escape), .ir(ir), .u_cond(u_cond), .cpu_cond(cpu_cond),
    .int_req(int_req), .irq_en(irq_en), .stall(stall),
    .uaddr(uaddr), .cond_true(cond_true), .fetch_start(fetch_start),
    .int_taken(int_taken), .seq_fault(seq_fault)
`ifdef USEQ_UBREAK_EN
    , .ubrk_addr(ubrk_addr), .ubrk_arm(ubrk_arm), .ubrk_hit(ubrk_hit)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int  m_page, m_opc, m_cyc;
  bit  m_fs, m_it, m_fault;
  logic [17:0] exp_q[$];

  function automatic bit model_cond(input logic [15:0] uc, input logic [15:0] cc,
                                    input logic src, input logic [3:0] sel, input logic inv);
    bit b;
    if (sel == 4'd15) b = 1'b1;
    else if (src) b = cc[sel];
    else b = uc[sel];
    return b ^ inv;
  endfunction

  always @(posedge clk) begin : model
    int  t;
    int  off_s;
    bit  c;
    logic [UADDR_W-1:0] ua;
    if (!rst_n) begin
      m_page = 0; m_opc = 0; m_cyc = 0;
      m_fs = 1; m_it = 0; m_fault = 0;
    end else if (stall) begin
      m_fs = 0; m_it = 0;
    end else begin
      c     = model_cond(u_cond, cpu_cond, cond_flag_src, cond_sel, cond_invert);
      off_s = (int'(offset) >= 64) ? int'(offset) - 128 : int'(offset);
      m_it  = 0;
      case (typ)
        2'd0, 2'd1: begin
          if (!c) t = m_cyc + 1;
          else if (typ == 2'd0) t = m_cyc + off_s;
          else t = int'(offset) % 64;
          if (t < 0 || t > 63) begin
            m_page = 0; m_opc = 0; m_cyc = 0; m_fault = 1;
          end else m_cyc = t;
        end
        2'd2: begin
          m_page = 0; m_cyc = 0;
          if (int_req && irq_en) begin m_opc = 255; m_it = 1; end
          else m_opc = 0;
        end
        default: begin m_page = int'(escape); m_opc = int'(ir); m_cyc = 0; end
      endcase
      m_fs = (m_page == 0 && m_opc == 0 && m_cyc == 0);
    end
    ua = UADDR_W'(m_page * 16384 + m_opc * 64 + m_cyc);
    exp_q.push_back({ua, m_fs, m_it, m_fault});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    logic [17:0] e;
    bit ec;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({uaddr, fetch_start, int_taken, seq_fault} !== e) begin
        n_err++;
        $display("FAIL model_outputs t=%0t: uaddr=%h fs=%b it=%b flt=%b, required uaddr=%h fs=%b it=%b flt=%b",
                 $time, uaddr, fetch_start, int_taken, seq_fault, e[17:3], e[2], e[1], e[0]);
      end
      ec = model_cond(u_cond, cpu_cond, cond_flag_src, cond_sel, cond_invert);
      n_cmp++;
      if (cond_true !== ec) begin
        n_err++;
        $display("FAIL model_cond_true t=%0t: got %b required %b", $time, cond_true, ec);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cw(input logic [1:0] t, input logic [6:0] off, input logic inv,
                        input logic src, input logic [3:0] sel, input logic esc, input logic [7:0] op);
    typ = t; offset = off; cond_invert = inv; cond_flag_src = src;
    cond_sel = sel; escape = esc; ir = op;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; stall = 1'b0; int_req = 1'b0; irq_en = 1'b0;
    u_cond = '0; cpu_cond = '0;
    set_cw(2'd3, 7'd0, 1'b0, 1'b0, 4'd15, 1'b0, 8'h00);
    tick(); tick();
    check("reset_uaddr", 32'(uaddr), 32'h0);
    check("reset_fetch_start", 32'(fetch_start), 32'h1);
    check("reset_int_taken", 32'(int_taken), 32'h0);
    check("reset_seq_fault", 32'(seq_fault), 32'h0);

    rst_n = 1'b1;
    set_cw(2'd3, 7'd0, 1'b0, 1'b0, 4'd15, 1'b0, 8'h2A); tick();
    check("dispatch_page0", 32'(uaddr), 32'h0A80);
    check("dispatch_fs_low", 32'(fetch_start), 32'h0);
    set_cw(2'd2, 7'd0, 1'b0, 1'b0, 4'd15, 1'b0, 8'h2A); tick();
    check("eoi_fetch_uaddr", 32'(uaddr), 32'h0);
    check("eoi_fetch_start", 32'(fetch_start), 32'h1);
    set_cw(2'd3, 7'd0, 1'b0, 1'b0, 4'd15, 1'b1, 8'h2A); tick();
    check("dispatch_escape", 32'(uaddr), 32'h4A80);

    set_cw(2'd1, 7'd5, 1'b0, 1'b0, 4'd15, 1'b0, 8'h00); tick();
    check("abs_to_5", 32'(uaddr), 32'h4A85);
    set_cw(2'd0, 7'h7D, 1'b0, 1'b0, 4'd15, 1'b0, 8'h00);
    #1 check("cond_always", 32'(cond_true), 32'h1);
    tick();
    check("rel_minus3", 32'(uaddr), 32'h4A82);
    set_cw(2'd1, 7'd5, 1'b0, 1'b0, 4'd15, 1'b0, 8'h00); tick();
    set_cw(2'd0, 7'h7D, 1'b1, 1'b0, 4'd15, 1'b0, 8'h00); tick();
    check("rel_inverted_inc", 32'(uaddr), 32'h4A86);

    set_cw(2'd1, 7'd10, 1'b0, 1'b0, 4'd15, 1'b0, 8'h00); tick();
    cpu_cond = 16'h0008;
    set_cw(2'd1, 7'h30, 1'b0, 1'b1, 4'd3, 1'b0, 8'h00); tick();
    check("abs_cpu_cond_taken", 32'(uaddr), 32'h4AB0);
    set_cw(2'd1, 7'd10, 1'b0, 1'b0, 4'd15, 1'b0, 8'h00); tick();
    cpu_cond = 16'h0000;
    set_cw(2'd1, 7'h30, 1'b0, 1'b1, 4'd3, 1'b0, 8'h00);
    #1 check("cond_cpu_false", 32'(cond_true), 32'h0);
    tick();
    check("abs_cpu_cond_not_taken", 32'(uaddr), 32'h4A8B);

    int_req = 1'b1; irq_en = 1'b1;
    set_cw(2'd2, 7'd0, 1'b0, 1'b0, 4'd15, 1'b0, 8'h00); tick();
    check("int_entry_uaddr", 32'(uaddr), 32'h3FC0);
    check("int_taken_pulse", 32'(int_taken), 32'h1);
    int_req = 1'b0;

    set_cw(2'd1, 7'd63, 1'b0, 1'b0, 4'd15, 1'b0, 8'h00); tick();
    check("abs_to_63", 32'(uaddr), 32'h3FFF);
    set_cw(2'd0, 7'd0, 1'b1, 1'b0, 4'd15, 1'b0, 8'h00); tick();
    check("overflow_uaddr", 32'(uaddr), 32'h0);
    check("overflow_fault", 32'(seq_fault), 32'h1);
    set_cw(2'd3, 7'd0, 1'b0, 1'b0, 4'd15, 1'b0, 8'h2A); tick(); tick();
    check("fault_sticky", 32'(seq_fault), 32'h1);

    set_cw(2'd2, 7'd0, 1'b0, 1'b0, 4'd15, 1'b0, 8'h2A);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int_req = (i == 1);
      tick();
      check("stall_hold_uaddr", 32'(uaddr), 32'h0A80);
      check("stall_no_int", 32'(int_taken), 32'h0);
    end
    stall = 1'b0; int_req = 1'b0; tick();
    check("stall_resume_fetch", 32'(uaddr), 32'h0);
    check("stall_resume_fs", 32'(fetch_start), 32'h1);
    check("stall_resume_no_int", 32'(int_taken), 32'h0);

    rst_n = 1'b0; stall = 1'b1; tick();
    check("reset_clears_fault", 32'(seq_fault), 32'h0);
    check("reset_mid_stall_uaddr", 32'(uaddr), 32'h0);
    rst_n = 1'b1; stall = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      stall = ($urandom_range(0, 7) == 0);
      int_req = 1'($urandom_range(0, 1));
      irq_en = 1'($urandom_range(0, 1));
      u_cond = 16'($urandom);
      cpu_cond = 16'($urandom);
      set_cw(2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)));
      tick();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
